// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch-stage PC unit.
//   fetch_state_e : BOOT / RUN / REDIRECT fetch sequencing states
//   btb_entry_t   : one branch-target-buffer entry {valid, tag, target}
//   FETCH_*       : default address/index widths and the mispredict counter width
// The BTB entry layout follows FETCH_ADDR_W / FETCH_BTB_INDEX_BITS, so the
// unit's ADDRESS_WIDTH / BTB_INDEX_BITS parameters must match these when the
// BTB is built (macro FETCH_BTB_EN).
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W         = 22;
  localparam int unsigned FETCH_BTB_INDEX_BITS = 3;
  localparam int unsigned FETCH_TAG_W          = FETCH_ADDR_W - FETCH_BTB_INDEX_BITS;
  localparam int unsigned FETCH_COUNT_W        = 16;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic                    valid;
    logic [FETCH_TAG_W-1:0]  tag;
    logic [FETCH_ADDR_W-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/fetch_btb.sv
// -----------------------------------------------------------------------------
// fetch_btb
// Direct-mapped branch target buffer.
//   i_Clk, i_Reset_n : clock, async active-low reset (clears every entry)
//   lookup_pc        : current fetch PC; lookup_hit/lookup_target are combinational
//   wr_en/wr_pc/wr_target : synchronous write of a resolved taken branch
// A write and a lookup to the same index in one cycle: the lookup returns the
// old entry because the array only changes on the clock edge.
// -----------------------------------------------------------------------------
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = FETCH_ADDR_W,
  parameter int unsigned BTB_INDEX_BITS = FETCH_BTB_INDEX_BITS
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic [ADDRESS_WIDTH-1:0] lookup_pc,
  output logic                     lookup_hit,
  output logic [ADDRESS_WIDTH-1:0] lookup_target,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_pc,
  input  logic [ADDRESS_WIDTH-1:0] wr_target
);

  localparam int unsigned NUM_ENTRIES = 1 << BTB_INDEX_BITS;

  btb_entry_t                entries_r [NUM_ENTRIES];
  btb_entry_t                rd_entry_s;
  logic [BTB_INDEX_BITS-1:0] rd_index_s;
  logic [BTB_INDEX_BITS-1:0] wr_index_s;

  assign rd_index_s = lookup_pc[BTB_INDEX_BITS-1:0];
  assign wr_index_s = wr_pc[BTB_INDEX_BITS-1:0];

  // Combinational lookup: hit needs a valid entry whose tag matches the upper PC bits
  always_comb begin
    rd_entry_s    = entries_r[rd_index_s];
    lookup_hit    = rd_entry_s.valid &&
                    (rd_entry_s.tag == lookup_pc[ADDRESS_WIDTH-1:BTB_INDEX_BITS]);
    lookup_target = rd_entry_s.target;
  end

  // Entry storage: cleared on reset, overwritten by each resolved taken branch
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        entries_r[i] <= '0;
      end
    end else if (wr_en) begin
      entries_r[wr_index_s] <= '{valid:  1'b1,
                                 tag:    wr_pc[ADDRESS_WIDTH-1:BTB_INDEX_BITS],
                                 target: wr_target};
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Fetch-stage program counter: picks the next fetch address from the
// predictor + BTB, and redirects/flushes when the ALU resolves a mispredict.
//   i_Clk, i_Reset_n        : clock, async active-low reset
//   i_Stall                 : hold the PC and fetch state
//   i_pred_taken            : predictor direction for o_IMEM_address
//   i_ALU_*                 : resolved branch from the ALU stage
//   o_IMEM_address          : registered fetch PC
//   o_fetch_valid           : registered; low in BOOT and REDIRECT bubbles
//   o_pred_taken/o_pred_target : combinational prediction for this fetch
//   o_flush                 : combinational mispredict indication
//   o_mispredict_count      : saturating mispredict counter
// Optional feature macro: FETCH_BTB_EN builds the BTB; without it the BTB
// never hits and fetch is purely sequential between redirects.
// -----------------------------------------------------------------------------
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH  = FETCH_ADDR_W,
  parameter int unsigned              BTB_INDEX_BITS = FETCH_BTB_INDEX_BITS,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC       = {ADDRESS_WIDTH{1'b0}}
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_Stall,
  input  logic                     i_pred_taken,
  input  logic                     i_ALU_isbranch,
  input  logic                     i_ALU_outcome,
  input  logic                     i_ALU_prediction,
  input  logic [ADDRESS_WIDTH-1:0] i_ALU_pc,
  input  logic [ADDRESS_WIDTH-1:0] i_ALU_target,
  input  logic [ADDRESS_WIDTH-1:0] i_ALU_pred_target,
  output logic [ADDRESS_WIDTH-1:0] o_IMEM_address,
  output logic                     o_fetch_valid,
  output logic                     o_pred_taken,
  output logic [ADDRESS_WIDTH-1:0] o_pred_target,
  output logic                     o_flush,
  output logic [FETCH_COUNT_W-1:0] o_mispredict_count
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_ONE    = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [FETCH_COUNT_W-1:0] COUNT_ONE = {{(FETCH_COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [FETCH_COUNT_W-1:0] COUNT_MAX = {FETCH_COUNT_W{1'b1}};

  fetch_state_e             state_r;
  logic                     fetch_valid_r;
  logic [ADDRESS_WIDTH-1:0] pc_r;
  logic [FETCH_COUNT_W-1:0] count_r;
  logic [ADDRESS_WIDTH-1:0] pc_plus1_s;
  logic [ADDRESS_WIDTH-1:0] redirect_pc_s;
  logic [ADDRESS_WIDTH-1:0] pred_target_s;
  logic [ADDRESS_WIDTH-1:0] btb_target_s;
  logic                     mispredict_s;
  logic                     btb_hit_s;
  logic                     pred_taken_s;

  // Sequential successor; wraps naturally at the top of the address space
  assign pc_plus1_s = pc_r + PC_ONE;

  // Mispredict: wrong direction, or taken to a different target than predicted
  always_comb begin
    mispredict_s = i_ALU_isbranch &&
                   ((i_ALU_outcome != i_ALU_prediction) ||
                    (i_ALU_outcome && (i_ALU_target != i_ALU_pred_target)));
    if (i_ALU_outcome) begin
      redirect_pc_s = i_ALU_target;
    end else begin
      redirect_pc_s = i_ALU_pc + PC_ONE;
    end
  end

`ifdef FETCH_BTB_EN
  logic btb_wr_s;

  // Every resolved taken branch trains the BTB, mispredicted or not
  assign btb_wr_s = i_ALU_isbranch & i_ALU_outcome;

  fetch_btb #(
    .ADDRESS_WIDTH  (ADDRESS_WIDTH),
    .BTB_INDEX_BITS (BTB_INDEX_BITS)
  ) u_btb (
    .i_Clk         (i_Clk),
    .i_Reset_n     (i_Reset_n),
    .lookup_pc     (pc_r),
    .lookup_hit    (btb_hit_s),
    .lookup_target (btb_target_s),
    .wr_en         (btb_wr_s),
    .wr_pc         (i_ALU_pc),
    .wr_target     (i_ALU_target)
  );
`else
  assign btb_hit_s    = 1'b0;
  assign btb_target_s = {ADDRESS_WIDTH{1'b0}};
`endif

  // Final prediction: only trust the predictor when the BTB knows a target
  always_comb begin
    pred_taken_s = i_pred_taken & btb_hit_s;
    if (pred_taken_s) begin
      pred_target_s = btb_target_s;
    end else begin
      pred_target_s = pc_plus1_s;
    end
  end

  // Fetch FSM with registered PC and valid; mispredict beats stall beats bubble
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      fetch_valid_r <= 1'b0;
    end else if (mispredict_s) begin
      state_r       <= ST_REDIRECT;
      pc_r          <= redirect_pc_s;
      fetch_valid_r <= 1'b0;
    end else if (i_Stall) begin
      state_r       <= state_r;
      pc_r          <= pc_r;
      fetch_valid_r <= fetch_valid_r;
    end else begin
      case (state_r)
        ST_RUN:      pc_r <= pred_target_s;
        ST_BOOT:     pc_r <= pc_r;
        ST_REDIRECT: pc_r <= pc_r;
        default:     pc_r <= pc_r;
      endcase
      state_r       <= ST_RUN;
      fetch_valid_r <= 1'b1;
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count_r <= {FETCH_COUNT_W{1'b0}};
    end else if (mispredict_s && (count_r != COUNT_MAX)) begin
      count_r <= count_r + COUNT_ONE;
    end
  end

  assign o_IMEM_address     = pc_r;
  assign o_fetch_valid      = fetch_valid_r;
  assign o_pred_taken       = pred_taken_s;
  assign o_pred_target      = pred_target_s;
  assign o_flush            = mispredict_s;
  assign o_mispredict_count = count_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized
// run, all compared against a behavioural model of fetch (PC, bubble flag,
// counter, and a BTB remembered as full branch PCs per slot).
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

  localparam int AW = 22;

  logic          i_Clk;
  logic          i_Reset_n;
  logic          i_Stall;
  logic          i_pred_taken;
  logic          i_ALU_isbranch;
  logic          i_ALU_outcome;
  logic          i_ALU_prediction;
  logic [AW-1:0] i_ALU_pc;
  logic [AW-1:0] i_ALU_target;
  logic [AW-1:0] i_ALU_pred_target;
  logic [AW-1:0] o_IMEM_address;
  logic          o_fetch_valid;
  logic          o_pred_taken;
  logic [AW-1:0] o_pred_target;
  logic          o_flush;
  logic [15:0]   o_mispredict_count;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [AW-1:0] m_pc;
  bit            m_bubble;
  int            m_count;
  bit            m_btb_valid [8];
  logic [AW-1:0] m_btb_pc    [8];
  logic [AW-1:0] m_btb_tgt   [8];

  fetch_pc_unit dut (
    .i_Clk              (i_Clk),
    .i_Reset_n          (i_Reset_n),
    .i_Stall            (i_Stall),
    .i_pred_taken       (i_pred_taken),
    .i_ALU_isbranch     (i_ALU_isbranch),
    .i_ALU_outcome      (i_ALU_outcome),
    .i_ALU_prediction   (i_ALU_prediction),
    .i_ALU_pc           (i_ALU_pc),
    .i_ALU_target       (i_ALU_target),
    .i_ALU_pred_target  (i_ALU_pred_target),
    .o_IMEM_address     (o_IMEM_address),
    .o_fetch_valid      (o_fetch_valid),
    .o_pred_taken       (o_pred_taken),
    .o_pred_target      (o_pred_target),
    .o_flush            (o_flush),
    .o_mispredict_count (o_mispredict_count)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  function automatic bit m_mispredict();
    return i_ALU_isbranch && ((i_ALU_outcome != i_ALU_prediction) ||
           (i_ALU_outcome && (i_ALU_target != i_ALU_pred_target)));
  endfunction

  function automatic bit m_pred_taken();
`ifdef FETCH_BTB_EN
    return i_pred_taken && m_btb_valid[m_pc[2:0]] && (m_btb_pc[m_pc[2:0]] == m_pc);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [AW-1:0] m_pred_target();
    if (m_pred_taken()) return m_btb_tgt[m_pc[2:0]];
    return m_pc + 22'd1;
  endfunction

  task automatic model_reset();
    m_pc = 22'd0;
    m_bubble = 1'b1;
    m_count = 0;
    for (int i = 0; i < 8; i++) m_btb_valid[i] = 1'b0;
  endtask

  task automatic set_idle();
    i_Stall = 1'b0; i_pred_taken = 1'b0;
    i_ALU_isbranch = 1'b0; i_ALU_outcome = 1'b0; i_ALU_prediction = 1'b0;
    i_ALU_pc = 22'd0; i_ALU_target = 22'd0; i_ALU_pred_target = 22'd0;
  endtask

  task automatic set_branch(input bit outcome, input bit pred, input logic [AW-1:0] pc,
                            input logic [AW-1:0] tgt, input logic [AW-1:0] ptgt);
    i_ALU_isbranch = 1'b1; i_ALU_outcome = outcome; i_ALU_prediction = pred;
    i_ALU_pc = pc; i_ALU_target = tgt; i_ALU_pred_target = ptgt;
  endtask

  // Advance one clock and move the model across the same edge
  task automatic tick();
    bit            mp;
    bit            wr;
    logic [AW-1:0] seq_next;
    logic [AW-1:0] redir;
    mp       = m_mispredict();
    seq_next = m_pred_target();
    redir    = i_ALU_outcome ? i_ALU_target : i_ALU_pc + 22'd1;
    wr       = i_ALU_isbranch && i_ALU_outcome;
    @(posedge i_Clk);
    if (mp) begin
      m_pc = redir; m_bubble = 1'b1;
      if (m_count < 65535) m_count++;
    end else if (!i_Stall) begin
      if (m_bubble) m_bubble = 1'b0;
      else m_pc = seq_next;
    end
    if (wr) begin
      m_btb_valid[i_ALU_pc[2:0]] = 1'b1;
      m_btb_pc[i_ALU_pc[2:0]]    = i_ALU_pc;
      m_btb_tgt[i_ALU_pc[2:0]]   = i_ALU_target;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [AW-1:0] exp_seq [5];
    bit            exp_vld [5];
    set_idle();
    i_Reset_n = 1'b0;
    model_reset();
    #12;
    vectors++; if (o_IMEM_address !== 22'd0) begin miscompares++; $display("FAIL reset_pc: got %0h want 0", o_IMEM_address); end
    vectors++; if (o_fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", o_fetch_valid); end
    vectors++; if (o_pred_taken !== 1'b0) begin miscompares++; $display("FAIL reset_pred_taken: got %0b want 0", o_pred_taken); end
    vectors++; if (o_flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %0b want 0", o_flush); end
    vectors++; if (o_mispredict_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", o_mispredict_count); end
    i_Reset_n = 1'b1;
    exp_seq = '{22'd0, 22'd0, 22'd1, 22'd2, 22'd3};
    exp_vld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ((o_IMEM_address !== exp_seq[i]) || (o_fetch_valid !== exp_vld[i])) begin
        miscompares++;
        $display("FAIL boot_seq[%0d]: got pc=%0h valid=%0b want pc=%0h valid=%0b", i, o_IMEM_address, o_fetch_valid, exp_seq[i], exp_vld[i]);
      end
      tick();
    end
  endtask

  task automatic test_empty_btb();
    logic [AW-1:0] prev;
    i_pred_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prev = o_IMEM_address;
      #1;
      vectors++; if (o_pred_taken !== 1'b0) begin miscompares++; $display("FAIL empty_btb_taken: got %0b want 0", o_pred_taken); end
      tick();
      vectors++; if (o_IMEM_address !== prev + 22'd1) begin miscompares++; $display("FAIL empty_btb_seq: got %0h want %0h", o_IMEM_address, prev + 22'd1); end
    end
    i_pred_taken = 1'b0;
  endtask

  task automatic test_branch_taken();
    int cnt0;
    cnt0 = m_count;
    set_branch(1'b1, 1'b0, 22'd5, 22'd40, 22'd0);
    #1;
    vectors++; if (o_flush !== 1'b1) begin miscompares++; $display("FAIL taken_flush: got %0b want 1", o_flush); end
    tick();
    set_idle();
    vectors++; if ((o_IMEM_address !== 22'd40) || (o_fetch_valid !== 1'b0)) begin miscompares++; $display("FAIL taken_redirect: got pc=%0h valid=%0b want pc=28 valid=0", o_IMEM_address, o_fetch_valid); end
    vectors++; if (o_mispredict_count !== 16'(cnt0 + 1)) begin miscompares++; $display("FAIL taken_count: got %0d want %0d", o_mispredict_count, cnt0 + 1); end
    tick();
    vectors++; if ((o_IMEM_address !== 22'd40) || (o_fetch_valid !== 1'b1)) begin miscompares++; $display("FAIL taken_resume: got pc=%0h valid=%0b want pc=28 valid=1", o_IMEM_address, o_fetch_valid); end
    // Steer fetch back to 5 via a target-mismatch redirect from an unrelated slot
    set_branch(1'b1, 1'b1, 22'd2, 22'd5, 22'd6);
    tick();
    set_idle();
    tick();
    i_pred_taken = 1'b1;
    #1;
`ifdef FETCH_BTB_EN
    vectors++; if ((o_pred_taken !== 1'b1) || (o_pred_target !== 22'd40)) begin miscompares++; $display("FAIL btb_hit: got taken=%0b tgt=%0h want taken=1 tgt=28", o_pred_taken, o_pred_target); end
`else
    vectors++; if ((o_pred_taken !== 1'b0) || (o_pred_target !== 22'd6)) begin miscompares++; $display("FAIL btb_off: got taken=%0b tgt=%0h want taken=0 tgt=6", o_pred_taken, o_pred_target); end
`endif
    tick();
    vectors++; if (o_IMEM_address !== m_pc) begin miscompares++; $display("FAIL btb_next_pc: got %0h want %0h", o_IMEM_address, m_pc); end
    i_pred_taken = 1'b0;
  endtask

  task automatic test_not_taken();
    int cnt0;
    cnt0 = m_count;
    set_branch(1'b0, 1'b1, 22'd5, 22'd77, 22'd40);
    #1;
    vectors++; if (o_flush !== 1'b1) begin miscompares++; $display("FAIL nt_flush: got %0b want 1", o_flush); end
    tick();
    set_idle();
    vectors++; if ((o_IMEM_address !== 22'd6) || (o_fetch_valid !== 1'b0)) begin miscompares++; $display("FAIL nt_redirect: got pc=%0h valid=%0b want pc=6 valid=0", o_IMEM_address, o_fetch_valid); end
    vectors++; if (o_mispredict_count !== 16'(cnt0 + 1)) begin miscompares++; $display("FAIL nt_count: got %0d want %0d", o_mispredict_count, cnt0 + 1); end
    tick();
  endtask

  task automatic test_stall();
    i_Stall = 1'b1;
    set_branch(1'b1, 1'b0, 22'd12, 22'd100, 22'd0);
    tick();
    set_idle();
    i_Stall = 1'b1;
    vectors++; if ((o_IMEM_address !== 22'd100) || (o_fetch_valid !== 1'b0)) begin miscompares++; $display("FAIL stall_redirect: got pc=%0h valid=%0b want pc=64 valid=0", o_IMEM_address, o_fetch_valid); end
    tick();
    vectors++; if ((o_IMEM_address !== 22'd100) || (o_fetch_valid !== 1'b0)) begin miscompares++; $display("FAIL stall_in_bubble: got pc=%0h valid=%0b want pc=64 valid=0", o_IMEM_address, o_fetch_valid); end
    i_Stall = 1'b0;
    tick();
    i_Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if ((o_IMEM_address !== 22'd100) || (o_fetch_valid !== 1'b1)) begin miscompares++; $display("FAIL stall_hold[%0d]: got pc=%0h valid=%0b want pc=64 valid=1", i, o_IMEM_address, o_fetch_valid); end
    end
    i_Stall = 1'b0;
    tick();
    vectors++; if (o_IMEM_address !== 22'd101) begin miscompares++; $display("FAIL stall_release: got %0h want 65", o_IMEM_address); end
  endtask

  task automatic test_wrap();
    set_branch(1'b1, 1'b1, 22'd3, 22'h3FFFFF, 22'd0);
    tick();
    set_idle();
    tick();
    vectors++; if ((o_IMEM_address !== 22'h3FFFFF) || (o_fetch_valid !== 1'b1)) begin miscompares++; $display("FAIL wrap_setup: got pc=%0h valid=%0b want pc=3fffff valid=1", o_IMEM_address, o_fetch_valid); end
    tick();
    vectors++; if (o_IMEM_address !== 22'd0) begin miscompares++; $display("FAIL wrap_seq: got %0h want 0", o_IMEM_address); end
    set_branch(1'b0, 1'b1, 22'h3FFFFF, 22'd9, 22'd9);
    tick();
    set_idle();
    vectors++; if (o_IMEM_address !== 22'd0) begin miscompares++; $display("FAIL wrap_alu_pc: got %0h want 0", o_IMEM_address); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      i_Stall           = ($urandom_range(3, 0) == 0);
      i_pred_taken      = 1'($urandom_range(1, 0));
      i_ALU_isbranch    = ($urandom_range(2, 0) == 0);
      i_ALU_outcome     = 1'($urandom_range(1, 0));
      i_ALU_prediction  = 1'($urandom_range(1, 0));
      i_ALU_pc          = 22'($urandom_range(31, 0));
      i_ALU_target      = 22'($urandom_range(63, 0));
      i_ALU_pred_target = ($urandom_range(1, 0) == 1) ? i_ALU_target : 22'($urandom_range(63, 0));
      #1;
      vectors++;
      if ((o_flush !== m_mispredict()) || (o_pred_taken !== m_pred_taken()) || (o_pred_target !== m_pred_target())) begin
        miscompares++;
        $display("FAIL rand_comb[%0d]: got flush=%0b taken=%0b tgt=%0h want flush=%0b taken=%0b tgt=%0h", i, o_flush, o_pred_taken, o_pred_target, m_mispredict(), m_pred_taken(), m_pred_target());
      end
      tick();
      vectors++;
      if ((o_IMEM_address !== m_pc) || (o_fetch_valid !== !m_bubble) || (o_mispredict_count !== 16'(m_count))) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: got pc=%0h valid=%0b cnt=%0d want pc=%0h valid=%0b cnt=%0d", i, o_IMEM_address, o_fetch_valid, o_mispredict_count, m_pc, !m_bubble, m_count);
      end
    end
    set_idle();
  endtask

  task automatic test_mid_reset();
    set_branch(1'b1, 1'b0, 22'd9, 22'd50, 22'd0);
    #2;
    i_Reset_n = 1'b0;
    #1;
    vectors++; if ((o_IMEM_address !== 22'd0) || (o_fetch_valid !== 1'b0) || (o_mispredict_count !== 16'd0)) begin miscompares++; $display("FAIL midreset_state: got pc=%0h valid=%0b cnt=%0d want 0 0 0", o_IMEM_address, o_fetch_valid, o_mispredict_count); end
    @(posedge i_Clk);
    #1;
    set_idle();
    model_reset();
    i_Reset_n = 1'b1;
    i_pred_taken = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1;
      vectors++;
      if ((o_pred_taken !== 1'b0) || (o_pred_taken !== m_pred_taken()) || (o_IMEM_address !== m_pc)) begin
        miscompares++;
        $display("FAIL midreset_btb[%0d]: got taken=%0b pc=%0h want taken=0 pc=%0h", i, o_pred_taken, o_IMEM_address, m_pc);
      end
      tick();
    end
    i_pred_taken = 1'b0;
  endtask

  task automatic test_saturate();
    set_branch(1'b0, 1'b1, 22'd20, 22'd0, 22'd0);
    for (int i = 1; i <= 65540; i++) begin
      tick();
      if (i == 65534) begin
        vectors++; if (o_mispredict_count !== 16'hFFFE) begin miscompares++; $display("FAIL sat_before: got %0h want fffe", o_mispredict_count); end
      end
    end
    vectors++; if ((o_mispredict_count !== 16'hFFFF) || (o_mispredict_count !== 16'(m_count))) begin miscompares++; $display("FAIL sat_hold: got %0h want ffff", o_mispredict_count); end
    vectors++; if ((o_IMEM_address !== 22'd21) || (o_fetch_valid !== 1'b0)) begin miscompares++; $display("FAIL b2b_redirect: got pc=%0h valid=%0b want pc=15 valid=0", o_IMEM_address, o_fetch_valid); end
    set_idle();
    tick();
    vectors++; if ((o_fetch_valid !== 1'b1) || (o_mispredict_count !== 16'hFFFF)) begin miscompares++; $display("FAIL sat_exit: got valid=%0b cnt=%0h want valid=1 cnt=ffff", o_fetch_valid, o_mispredict_count); end
  endtask

  initial begin
    test_reset();
    test_empty_btb();
    test_branch_taken();
    test_not_taken();
    test_stall();
    test_wrap();
    test_random();
    test_mid_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-stage program-counter unit sitting directly upstream of the branch predictor. Each cycle it drives the fetch address used both by instruction memory and by the predictor's lookup. It combines the predictor's `o_taken` with an internal branch target buffer (BTB) to choose the next PC. It also redirects fetch and flushes younger instructions when the ALU stage resolves a mispredicted branch.

## Interface
- `ADDRESS_WIDTH`, 22: width of word-addressed PC.
- `BTB_INDEX_BITS`, 3: log2 of BTB entries; the BTB has 8 entries by default.
- `RESET_PC`, 0: fetch address after reset.
- `i_Clk`  in  1  clock; all state updates on the rising edge.
- `i_Reset_n`  in  1  asynchronous, active-low reset.
- `i_Stall`  in  1  hold current PC (IMEM/decode not ready).
- `i_pred_taken`  in  1  predictor's `o_taken` for the current `o_IMEM_address`.
- `i_ALU_isbranch`  in  1  instruction in ALU stage is a branch.
- `i_ALU_outcome`  in  1  resolved direction: 1 = taken.
- `i_ALU_prediction`  in  1  direction predicted for that branch.
- `i_ALU_pc`  in  ADDRESS_WIDTH  PC of ALU-stage branch.
- `i_ALU_target`  in  ADDRESS_WIDTH  resolved taken target.
- `i_ALU_pred_target`  in  ADDRESS_WIDTH  target predicted at fetch, carried down the pipe.
- `o_IMEM_address`  out  ADDRESS_WIDTH  registered fetch PC; also feeds the predictor's `i_IMEM_address`.
- `o_fetch_valid`  out  1  `o_IMEM_address` is a real fetch, not a bubble.
- `o_pred_taken`  out  1  final taken prediction for this fetch (predictor AND BTB hit).
- `o_pred_target`  out  ADDRESS_WIDTH  predicted next PC for this fetch.
- `o_flush`  out  1  kill younger in-flight instructions (combinational).
- `o_mispredict_count`  out  16  saturating mispredict counter.

## Operation
- FSM states:
  - BOOT: entered on reset; lasts one cycle; `o_fetch_valid` is 0. Moves to RUN.
  - RUN: normal fetch.
  - REDIRECT: one bubble cycle after a mispredict; `o_fetch_valid` is 0. Moves to RUN.
- Mispredict condition: `i_ALU_isbranch` AND (outcome != prediction OR (outcome = 1 AND `i_ALU_target` != `i_ALU_pred_target`)).
- `o_flush` equals the mispredict condition, in any state.
- BTB lookup:
  - Index = `o_IMEM_address[BTB_INDEX_BITS-1:0]`.
  - Hit = valid AND tag equals the upper PC bits.
  - Lookup is combinational.
- `o_pred_taken` = `i_pred_taken` AND hit.
- `o_pred_target` = BTB target when `o_pred_taken` is 1, otherwise PC+1.
- Next-PC priority (highest first):
  1. Mispredict: `i_ALU_outcome` ? `i_ALU_target` : `i_ALU_pc`+1. Next state is REDIRECT.
  2. `i_Stall`: hold the PC.
  3. State BOOT or REDIRECT: hold the PC (bubble).
  4. Otherwise: `o_pred_target`.
- PC+1 wraps modulo 2^ADDRESS_WIDTH; there is no overflow flag.
- BTB update on a resolved taken branch (`i_ALU_isbranch` AND `i_ALU_outcome`):
  - Write valid=1, tag and target into the entry indexed by `i_ALU_pc`.
  - The update happens whether or not the branch was mispredicted.
  - Not-taken branches leave the BTB unchanged.
- Same-cycle BTB write and lookup to the same index: the lookup sees the old contents.
- `o_mispredict_count` increments by 1 on each mispredict cycle and saturates at 16'hFFFF.

## Timing
- Reset, asynchronous:
  - PC = `RESET_PC`; state = BOOT; all BTB valid bits cleared; count = 0.
  - Output values during reset: `o_fetch_valid` 0, `o_pred_taken` 0, `o_flush` 0 while ALU inputs are low.
- Redirect latency: the mispredict is seen in cycle N; the corrected PC appears on `o_IMEM_address` after edge N+1.
- `o_fetch_valid` is low in cycle N+1 and returns high in cycle N+2.
- Stall asserted in cycle N: the PC is unchanged after edge N+1, and `o_fetch_valid` stays as it was.
- A mispredict during a stall or in BOOT takes priority and redirects.
- A mispredict while in REDIRECT (back-to-back) redirects again and stays in REDIRECT.
- Reset asserted mid-operation returns to BOOT immediately; no partial BTB write survives.

## Configuration
- `FETCH_BTB_EN` defined: behaviour as above.
- `FETCH_BTB_EN` undefined:
  - No BTB storage; hit is always 0.
  - `o_pred_taken` is 0 and the next PC is always PC+1 unless redirected.
  - Mispredict and redirect logic is unchanged.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (BOOT/RUN/REDIRECT);
  - the BTB entry struct {valid, tag, target};
  - the count width constant (16).
- Sub-module `fetch_btb` holds the storage, the combinational lookup port and the synchronous write port. It is instantiated only under `FETCH_BTB_EN`.

## Test plan
- Reset release → `o_IMEM_address`=0 with `o_fetch_valid`=0 for one cycle, then 0,1,2,3 with valid=1.
- `i_pred_taken`=1 with an empty BTB → PC increments sequentially and `o_pred_taken`=0.
- ALU resolves taken at pc=5, target=40, prediction 0 → `o_flush`=1 that cycle; next address is 40 with valid=0; count becomes 1. A later fetch at 5 with `i_pred_taken`=1 → next PC 40 with `o_pred_taken`=1.
- Predicted taken at pc=5 but resolved not-taken → redirect to 6; count increments.
- `i_Stall`=1 together with a mispredict → redirect wins. `i_Stall` alone → PC held for 3 cycles.
- PC=22'h3FFFFF with no branch → next PC is 0. Force 65536 mispredicts → count holds at 16'hFFFF.
